imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Upstream companion of the pipelined core. Owns the 16-word x 16-bit instruction memory.
- Accepts a program over a valid/ready load stream and holds the core in reset while loading.
- Releases core reset a fixed delay after the last word is accepted, then serves combinational instruction reads to the core's fetch stage.

Parameters:
- ADDR_W, 4, instruction address width (matches the core's address_to_instruction_memory)
- DATA_W, 16, instruction word width
- DEPTH, 16, number of instruction words (2**ADDR_W)
- RELEASE_DELAY, 4, cycles between last-word acceptance and core_reset deassertion (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- load_valid  input  1  load word present
- load_data  input  DATA_W  instruction word to store
- load_last  input  1  qualifies the final word of the program
- load_ready  output  1  loader can accept a word this cycle
- reload  input  1  single-cycle request to reload a new program while running
- address_to_instruction_memory  input  ADDR_W  fetch address from the core
- data_from_instruction_memory  output  DATA_W  instruction word to the core
- core_reset  output  1  active-high reset to the core
- word_count  output  ADDR_W+1  number of words accepted in the current load
- load_done  output  1  high in RUN
- load_error  output  1  overflow flag, sticky until reset

Behaviour:
- Reset (asynchronous): state=LOAD, all memory words=0x0000, write pointer=0, word_count=0, delay counter=0, core_reset=1, load_ready=1, load_done=0, load_error=0.
- FSM states: LOAD, HOLD, RUN, ERROR.
- LOAD:
  - load_ready=1, core_reset=1.
  - Handshake: a word is accepted when load_valid && load_ready at the rising edge. It is written to mem[wptr], then wptr and word_count are incremented.
  - Accepted word with load_last=1 -> HOLD, delay counter loaded with RELEASE_DELAY-1.
  - Accepted word at wptr==DEPTH-1 with load_last=0 -> ERROR. The word is still written, and word_count becomes 16.
  - load_valid with load_ready=0 has no effect. The source holds the word until it is accepted.
- HOLD:
  - load_ready=0, core_reset=1.
  - The counter decrements each cycle; at 0 -> RUN.
  - core_reset therefore falls exactly RELEASE_DELAY cycles after the accepting edge.
- RUN:
  - core_reset=0, load_done=1, load_ready=0.
  - reload=1 -> LOAD on the next edge. In that same edge: all words are cleared to 0x0000, wptr=0, word_count=0, core_reset=1.
- ERROR:
  - load_ready=0, core_reset=1, load_error=1.
  - reload is ignored; only reset exits ERROR.
- Read port:
  - data_from_instruction_memory = mem[address_to_instruction_memory], combinational (the core registers the fetched instruction itself).
  - Reads 0x0000 in every state except RUN, so the core never sees a partially loaded program.
  - Words beyond the last loaded word read 0x0000.
- reload outside RUN is ignored.
- A zero-length program is impossible: load_last is only meaningful on an accepted word.
- Reset mid-load or mid-HOLD aborts immediately. Memory is cleared and the core stays in reset.
- All outputs are registered or decoded from registered state, with no input-to-output combinational path except the read port.

Decomposition:
- Shared package imem_loader_pkg:
  - state encoding enum {LOAD, HOLD, RUN, ERROR} (2 bits)
  - the NOP/zero word constant 0x0000
  - DEPTH derived from ADDR_W
- One natural sub-module: imem_array, the DEPTH x DATA_W register array. It provides async clear, synchronous clear-all, a single write port and a combinational read port.
- The FSM, pointer and delay counter stay in imem_loader.

Test Plan:
- Basic load: after reset, stream 0x1111, 0x2222, 0x3333 (last on third) with continuous valid -> word_count=3; core_reset falls 4 cycles after third acceptance; in RUN, addresses 0/1/2/3 read 0x1111/0x2222/0x3333/0x0000.
- Backpressure and gaps: insert idle cycles between load_valid pulses -> only asserted-valid words are stored; none are duplicated or dropped; word_count matches the number of handshakes.
- Read masking: during LOAD and HOLD, drive address 0 after writing 0xABCD -> read 0x0000; it reads 0xABCD only once load_done=1.
- Overflow: send 16 words with load_last=0 -> load_error=1, word_count=16, load_ready=0, core_reset stays 1; reload pulse has no effect; reset clears the error.
- Reload: in RUN, pulse reload -> next cycle core_reset=1, all reads 0x0000, word_count=0. Load 0x00FF (last) -> address 0 reads 0x00FF in RUN and address 1 reads 0x0000.
- Reset mid-HOLD: assert reset 2 cycles after last-word acceptance -> state LOAD, memory cleared, core_reset held 1, load_ready=1 immediately (asynchronous).

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// =============================================================================
// imem_loader_pkg : shared constants and FSM encoding for the instruction loader
// Revision: 1.0
// =============================================================================
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 4;
  localparam int IMEM_DATA_W = 16;
  localparam int IMEM_DEPTH  = 2 ** IMEM_ADDR_W;
  localparam int DELAY_W     = 4;

  localparam logic [IMEM_DATA_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } loader_state_e;

  // The accepting edge itself counts as the first cycle of the release delay.
  function automatic logic [DELAY_W-1:0] delay_preset(input int release_delay);
    return DELAY_W'(release_delay - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// =============================================================================
// imem_array : DEPTH x DATA_W register array, one write port, combinational read
// Revision: 1.0
// =============================================================================
module imem_array
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_all,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Clear-all wins over a write in the same cycle.
  always_comb begin
    mem_d = mem_q;
    if (clear_all) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = DATA_W'(NOP_WORD);
      end
    end else if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(NOP_WORD);
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// =============================================================================
// imem_loader : streams a program into instruction memory, holds the core in
//               reset while loading and serves fetches once the program runs
// Revision: 1.0
// =============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W        = IMEM_ADDR_W,
  parameter int DATA_W        = IMEM_DATA_W,
  parameter int DEPTH         = 2 ** ADDR_W,
  parameter int RELEASE_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] address_to_instruction_memory,
  output logic [DATA_W-1:0] data_from_instruction_memory,
  output logic              core_reset,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done,
  output logic              load_error
);

  loader_state_e      state_q, state_d;
  logic [ADDR_W-1:0]  wptr_q, wptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [DELAY_W-1:0] delay_q, delay_d;

  logic              accept;
  logic              clear_all;
  logic [DATA_W-1:0] rd_data;

  imem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_imem_array (
    .clk       (clk),
    .reset     (reset),
    .clear_all (clear_all),
    .wr_en     (accept),
    .wr_addr   (wptr_q),
    .wr_data   (load_data),
    .rd_addr   (address_to_instruction_memory),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      wptr_q  <= '0;
      count_q <= '0;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      delay_q <= delay_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    delay_d   = delay_q;
    accept    = 1'b0;
    clear_all = 1'b0;
    case (state_q)
      ST_LOAD: begin
        // load_ready is high for the whole of LOAD, so valid alone completes the handshake.
        if (load_valid) begin
          accept  = 1'b1;
          wptr_d  = wptr_q + 1'b1;
          count_d = count_q + 1'b1;
          if (load_last) begin
            state_d = ST_HOLD;
            delay_d = delay_preset(RELEASE_DELAY);
          end else if (wptr_q == ADDR_W'(DEPTH - 1)) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_HOLD: begin
        if (delay_q == '0) begin
          state_d = ST_RUN;
        end else begin
          delay_d = delay_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_d   = ST_LOAD;
          wptr_d    = '0;
          count_d   = '0;
          clear_all = 1'b1;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    core_reset = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state_q)
      ST_LOAD:  load_ready = 1'b1;
      ST_RUN: begin
        core_reset = 1'b0;
        load_done  = 1'b1;
      end
      ST_ERROR: load_error = 1'b1;
      default: ;
    endcase
  end

  assign word_count = count_q;

  // Fetches see NOPs until the whole program is in place.
  assign data_from_instruction_memory =
      (state_q == ST_RUN) ? rd_data : DATA_W'(NOP_WORD);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// =============================================================================
// tb_imem_loader : directed + randomized bench with a program-list reference model
// Revision: 1.0
// =============================================================================
module tb_imem_loader;

  localparam int ADDR_W        = 4;
  localparam int DATA_W        = 16;
  localparam int DEPTH         = 16;
  localparam int RELEASE_DELAY = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              reload;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic              core_reset;
  logic [ADDR_W:0]   word_count;
  logic              load_done;
  logic              load_error;

  int checks = 0;
  int errors = 0;

  // Reference model: the accepted program as a list, plus whether it is running.
  logic [DATA_W-1:0] model_words[$];
  bit                model_run;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .DEPTH         (DEPTH),
    .RELEASE_DELAY (RELEASE_DELAY)
  ) dut (
    .clk                           (clk),
    .reset                         (reset),
    .load_valid                    (load_valid),
    .load_data                     (load_data),
    .load_last                     (load_last),
    .load_ready                    (load_ready),
    .reload                        (reload),
    .address_to_instruction_memory (addr),
    .data_from_instruction_memory  (rdata),
    .core_reset                    (core_reset),
    .word_count                    (word_count),
    .load_done                     (load_done),
    .load_error                    (load_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_read(input int a);
    if (!model_run || a >= model_words.size()) return '0;
    return model_words[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic [DATA_W-1:0] junk;
    load_valid = 1'b0;
    repeat (n) begin
      junk      = DATA_W'($urandom);
      load_data = junk;
      load_last = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input bit last);
    check("ready_before_accept", load_ready, 1);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    model_words.push_back(d);
    check("word_count", word_count, model_words.size());
    check("masked_read_addr0", rdata, 0);
    check("not_done_while_loading", load_done, 0);
  endtask

  task automatic load_program(input int n, input bit gaps);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      if (gaps) idle($urandom_range(0, 3));
      w = DATA_W'($urandom);
      send_word(w, i == n - 1);
    end
  endtask

  task automatic expect_release();
    int k = 0;
    check("hold_ready_low", load_ready, 0);
    check("hold_core_reset", core_reset, 1);
    while (core_reset === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check("release_delay", k, RELEASE_DELAY);
    model_run = 1'b1;
    check("run_load_done", load_done, 1);
  endtask

  task automatic check_reads();
    for (int a = 0; a < DEPTH; a++) begin
      addr = ADDR_W'(a);
      @(negedge clk);
      check("read", rdata, exp_read(a));
    end
    addr = '0;
    tick();
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    model_words.delete();
    model_run = 1'b0;
    check("reload_core_reset", core_reset, 1);
    check("reload_word_count", word_count, 0);
    check("reload_ready", load_ready, 1);
    check("reload_not_done", load_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    reload     = 1'b0;
    addr       = '0;
    model_run  = 1'b0;
    #3;
    check("rst_core_reset", core_reset, 1);
    check("rst_load_ready", load_ready, 1);
    check("rst_load_done", load_done, 0);
    check("rst_load_error", load_error, 0);
    check("rst_word_count", word_count, 0);
    check("rst_read", rdata, 0);
    tick();
    reset = 1'b0;
    tick();

    // Basic three-word program with continuous valid.
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    send_word(16'h3333, 1'b1);
    expect_release();
    check_reads();

    // Reload clears everything; a shorter program must not expose old words.
    do_reload();
    check_reads();
    send_word(16'h00FF, 1'b1);
    expect_release();
    check_reads();

    // reload during LOAD is ignored.
    do_reload();
    send_word(16'hABCD, 1'b0);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("reload_in_load_ignored", word_count, 1);
    idle(2);
    send_word(16'h5A5A, 1'b1);
    expect_release();
    check_reads();

    // Randomized programs with idle gaps between handshakes.
    repeat (4) begin
      do_reload();
      load_program($urandom_range(1, 15), 1'b1);
      expect_release();
      check_reads();
    end

    // Full 16-word program ending exactly at the last slot is legal.
    do_reload();
    load_program(16, 1'b0);
    check("full_no_error", load_error, 0);
    expect_release();
    check_reads();

    // Overflow: 16 words without last.
    do_reload();
    for (int i = 0; i < DEPTH; i++) send_word(DATA_W'($urandom), 1'b0);
    check("ovf_error", load_error, 1);
    check("ovf_count", word_count, 16);
    check("ovf_ready", load_ready, 0);
    check("ovf_core_reset", core_reset, 1);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    idle(2);
    check("ovf_reload_ignored_err", load_error, 1);
    check("ovf_reload_ignored_rst", core_reset, 1);
    check("ovf_reload_ignored_cnt", word_count, 16);
    #2 reset = 1'b1;
    #1;
    check("ovf_reset_clears_err", load_error, 0);
    check("ovf_reset_ready", load_ready, 1);
    model_words.delete();
    model_run = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Reset two cycles into HOLD aborts and clears memory.
    load_program(3, 1'b0);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("midhold_ready", load_ready, 1);
    check("midhold_core_reset", core_reset, 1);
    check("midhold_count", word_count, 0);
    check("midhold_done", load_done, 0);
    model_words.delete();
    model_run = 1'b0;
    tick();
    reset = 1'b0;
    idle(10);
    check("midhold_core_stays_reset", core_reset, 1);
    send_word(16'h0F0F, 1'b1);
    expect_release();
    check_reads();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
